// File: rtl/i2s_fifo_tx.sv
// rtl/i2s_fifo_tx.sv - FIFO-fed Philips I2S transmitter with MCLK/SCLK/LRCK generation
//
// Pops 16-bit samples from a first-word-fall-through FIFO once or twice per
// 2048-clk audio frame and serializes them as I2S (one-bit delay, 16 valid
// bits per 32-bit slot, zero padded). Underruns repeat the previous sample.
//
// Ports:
//   clk          in   system clock (100 MHz)
//   rst          in   synchronous active-high reset
//   fifo_dout    in   head-of-FIFO sample, valid while fifo_empty=0
//   fifo_empty   in   FIFO holds no data
//   fifo_rd      out  one-clk pop strobe, head consumed on the same edge
//   mclk         out  clk/4 DAC master clock
//   sclk         out  clk/32 serial bit clock
//   lrck         out  clk/2048 word select (0 = left, 1 = right)
//   sdout        out  serial data
//   underrun     out  one-clk pulse when a scheduled pop finds the FIFO empty
//   underrun_cnt out  saturating underrun count
module i2s_fifo_tx #(
  parameter bit STEREO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic        mclk,
  output logic        sclk,
  output logic        lrck,
  output logic        sdout,
  output logic        underrun,
  output logic [7:0]  underrun_cnt
);

  logic [10:0] cnt_q, cnt_d;
  logic [15:0] l_smp_q, l_smp_d;
  logic [15:0] r_smp_q, r_smp_d;
  logic        sdout_q, sdout_d;
  logic [7:0]  underrun_cnt_q, underrun_cnt_d;

  logic        sched;
  logic [5:0]  slot_nxt;
  logic [5:0]  l_idx;
  logic [5:0]  r_idx;

  // Pop instants: cnt=8 for the left (or mono) word, cnt=1032 for the right
  // word in stereo mode. Both sit inside zero-padded slots, so the sample
  // registers never change while a data slot is reading them.
  always_comb begin
    sched    = !rst && ((cnt_q == 11'd8) || (STEREO && (cnt_q == 11'd1032)));
    fifo_rd  = sched && !fifo_empty;
    underrun = sched && fifo_empty;
  end

  always_comb begin
    cnt_d          = cnt_q + 11'd1;
    l_smp_d        = l_smp_q;
    r_smp_d        = r_smp_q;
    underrun_cnt_d = underrun_cnt_q;
    sdout_d        = sdout_q;

    // cnt[10] tells the two pop instants apart.
    if (fifo_rd && !cnt_q[10]) begin
      l_smp_d = fifo_dout;
      if (!STEREO) begin
        r_smp_d = fifo_dout;
      end
    end
    if (fifo_rd && cnt_q[10]) begin
      r_smp_d = fifo_dout;
    end

    if (underrun && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end

    // sdout is loaded one clk ahead of each slot so it changes together with
    // the sclk falling edge; slot_nxt wraps 63 -> 0 at the frame boundary.
    slot_nxt = cnt_q[10:5] + 6'd1;
    l_idx    = 6'd16 - slot_nxt;
    r_idx    = 6'd48 - slot_nxt;
    if (cnt_q[4:0] == 5'd31) begin
      sdout_d = 1'b0;
      if ((slot_nxt >= 6'd1) && (slot_nxt <= 6'd16)) begin
        sdout_d = l_smp_q[l_idx[3:0]];
      end else if ((slot_nxt >= 6'd33) && (slot_nxt <= 6'd48)) begin
        sdout_d = r_smp_q[r_idx[3:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= 11'd0;
      l_smp_q        <= 16'd0;
      r_smp_q        <= 16'd0;
      sdout_q        <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      cnt_q          <= cnt_d;
      l_smp_q        <= l_smp_d;
      r_smp_q        <= r_smp_d;
      sdout_q        <= sdout_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign mclk         = cnt_q[1];
  assign sclk         = cnt_q[4];
  assign lrck         = cnt_q[10];
  assign sdout        = sdout_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_fifo_tx.sv
// tb/tb_i2s_fifo_tx.sv - testbench for i2s_fifo_tx (mono and stereo instances)
module tb_i2s_fifo_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic chk_en = 1'b0;
  int   nvec = 0;
  int   nbad = 0;

  // Bench-side FIFOs, index 0 = mono DUT, 1 = stereo DUT.
  logic [15:0] mem [2][64];
  int          hd [2] = '{0, 0};
  int          tl [2] = '{0, 0};
  logic        rnd = 1'b0;
  logic        rnd_e = 1'b0;
  logic [15:0] rnd_d = 16'd0;

  logic        emp_m, emp_s;
  logic [15:0] dout_m, dout_s;
  assign emp_m  = rnd ? rnd_e : (hd[0] == tl[0]);
  assign emp_s  = rnd ? rnd_e : (hd[1] == tl[1]);
  assign dout_m = rnd ? rnd_d : mem[0][hd[0]];
  assign dout_s = rnd ? rnd_d : mem[1][hd[1]];

  logic       rd_m, mclk_m, sclk_m, lrck_m, sd_m, ur_m;
  logic [7:0] uc_m;
  logic       rd_s, mclk_s, sclk_s, lrck_s, sd_s, ur_s;
  logic [7:0] uc_s;

  i2s_fifo_tx #(.STEREO(1'b0)) dut_m (
    .clk(clk), .rst(rst), .fifo_dout(dout_m), .fifo_empty(emp_m),
    .fifo_rd(rd_m), .mclk(mclk_m), .sclk(sclk_m), .lrck(lrck_m),
    .sdout(sd_m), .underrun(ur_m), .underrun_cnt(uc_m)
  );

  i2s_fifo_tx #(.STEREO(1'b1)) dut_s (
    .clk(clk), .rst(rst), .fifo_dout(dout_s), .fifo_empty(emp_s),
    .fifo_rd(rd_s), .mclk(mclk_s), .sclk(sclk_s), .lrck(lrck_s),
    .sdout(sd_s), .underrun(ur_s), .underrun_cnt(uc_s)
  );

  always @(posedge clk) begin
    if (rd_m) hd[0] <= hd[0] + 1;
    if (rd_s) hd[1] <= hd[1] + 1;
  end

  // Reference model: frame position, held samples and underrun counts.
  int          p = 0;
  int          fr = 0;
  logic [15:0] ml [2] = '{16'd0, 16'd0};
  logic [15:0] mr [2] = '{16'd0, 16'd0};
  int          uc [2] = '{0, 0};

  always @(posedge clk) begin
    if (rst) begin
      p = 0;
      fr = 0;
      for (int i = 0; i < 2; i++) begin
        ml[i] = 16'd0;
        mr[i] = 16'd0;
        uc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic        e;
        logic [15:0] d;
        e = (i == 0) ? emp_m : emp_s;
        d = (i == 0) ? dout_m : dout_s;
        if (p == 8 || (i == 1 && p == 1032)) begin
          if (!e) begin
            if (p == 8) ml[i] = d;
            if (p == 1032 || i == 0) mr[i] = d;
          end else if (uc[i] < 255) begin
            uc[i] = uc[i] + 1;
          end
        end
      end
      p = (p + 1) % 2048;
      if (p == 0) fr = fr + 1;
    end
  end

  function automatic logic exp_sd(input int c, input logic [15:0] l, input logic [15:0] r);
    int k;
    k = c / 32;
    if (k >= 1 && k <= 16) return l[16 - k];
    if (k >= 33 && k <= 48) return r[48 - k];
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      if (nbad <= 20)
        $display("FAIL %s at t=%0t frame=%0d cnt=%0d: got %h, expected %h", nm, $time, fr, p, act, exp);
    end
  endtask

  logic [63:0] fw [2];
  logic        prev_l [2];
  logic        prev_s [2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic       rd, mc, sc, lr, sd, ur, e, sch;
        logic [7:0] ucv;
        rd  = (i == 0) ? rd_m   : rd_s;
        mc  = (i == 0) ? mclk_m : mclk_s;
        sc  = (i == 0) ? sclk_m : sclk_s;
        lr  = (i == 0) ? lrck_m : lrck_s;
        sd  = (i == 0) ? sd_m   : sd_s;
        ur  = (i == 0) ? ur_m   : ur_s;
        ucv = (i == 0) ? uc_m   : uc_s;
        e   = (i == 0) ? emp_m  : emp_s;
        sch = (p == 8) || (i == 1 && p == 1032);
        chk("fifo_rd", 16'(rd), 16'(!rst && sch && !e));
        chk("underrun", 16'(ur), 16'(!rst && sch && e));
        chk("mclk", 16'(mc), 16'((p / 2) % 2));
        chk("sclk", 16'(sc), 16'((p / 16) % 2));
        chk("lrck", 16'(lr), 16'((p / 1024) % 2));
        chk("sdout", 16'(sd), 16'(exp_sd(p, ml[i], mr[i])));
        chk("underrun_cnt", 16'(ucv), 16'(uc[i]));
        if (lr != prev_l[i]) chk("lrck_on_sclk_fall", {14'd0, prev_s[i], sc}, 16'd2);
        prev_l[i] = lr;
        prev_s[i] = sc;
        if (p % 32 == 16) fw[i] = {fw[i][62:0], sd};
      end
    end
  end

  task automatic wait_at(input int f, input int c);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    while (!hit && n < 40000) begin
      @(negedge clk);
      #1;
      n++;
      hit = (fr == f && p == c);
    end
    if (!hit) begin
      nvec++;
      nbad++;
      $display("FAIL wait_at frame=%0d cnt=%0d: not reached, expected to be reached", f, c);
    end
  endtask

  task automatic push(input int i, input logic [15:0] w);
    mem[i][tl[i]] = w;
    tl[i] = tl[i] + 1;
  endtask

  initial begin
    rst = 1'b1;
    rnd = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      rnd_e = 1'($urandom_range(0, 1));
      rnd_d = 16'($urandom);
    end
    chk("rst_sdout", 16'(sd_m), 16'd0);
    chk("rst_uc", 16'(uc_s), 16'd0);
    push(0, 16'hA5C3);
    push(0, 16'h0001);
    push(1, 16'h8001);
    push(1, 16'h7FFE);
    rnd = 1'b0;
    rst = 1'b0;

    wait_at(0, 7);
    chk("no_pop_cnt7", 16'(rd_m), 16'd0);
    wait_at(0, 8);
    chk("first_pop_m", 16'(rd_m), 16'd1);
    chk("first_pop_s", 16'(rd_s), 16'd1);
    wait_at(0, 1100);
    push(1, 16'h1111); push(1, 16'h2222); push(1, 16'h3333);
    push(1, 16'h4444); push(1, 16'h5555); push(1, 16'h6666);
    wait_at(0, 2047);
    chk("mono_f0_L", fw[0][62:47], 16'hA5C3);
    chk("mono_f0_R", fw[0][30:15], 16'hA5C3);
    chk("mono_f0_pad", 16'({fw[0][63], fw[0][46:31], fw[0][14:0]} != 0), 16'd0);
    chk("st_f0_L", fw[1][62:47], 16'h8001);
    chk("st_f0_R", fw[1][30:15], 16'h7FFE);

    wait_at(1, 100);
    push(0, 16'h1234);
    wait_at(1, 2047);
    chk("mono_f1", fw[0], {1'b0, 16'h0001, 16'h0000, 16'h0001, 15'h0000});
    wait_at(2, 2047);
    chk("mono_f2_L", fw[0][62:47], 16'h1234);
    wait_at(4, 2047);
    chk("mono_f4_repeat", fw[0], {1'b0, 16'h1234, 16'h0000, 16'h1234, 15'h0000});
    chk("st_f4_repeat", fw[1], {1'b0, 16'h5555, 16'h0000, 16'h6666, 15'h0000});
    chk("uc_m_f4", 16'(uc_m), 16'd2);
    chk("uc_s_f4", 16'(uc_s), 16'd2);

    wait_at(5, 100);
    force dut_m.underrun_cnt_q = 8'd250;
    uc[0] = 250;
    @(negedge clk);
    #1 release dut_m.underrun_cnt_q;
    wait_at(10, 9);
    chk("uc_sat_reach", 16'(uc_m), 16'd255);
    wait_at(12, 8);
    chk("ur_pulse_f12", 16'(ur_m), 16'd1);
    chk("no_rd_empty", 16'(rd_m), 16'd0);
    wait_at(12, 1100);
    chk("uc_sat_hold", 16'(uc_m), 16'd255);
    push(1, 16'hAAAA); push(1, 16'hBBBB); push(1, 16'hCCCC); push(1, 16'hDDDD);
    push(0, 16'h0F0F); push(0, 16'hF0F0);

    wait_at(13, 700);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_mclk", 16'(mclk_m), 16'd0);
    chk("mid_rst_uc", 16'(uc_m), 16'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_at(0, 8);
    chk("rst_pop_m", 16'(rd_m), 16'd1);
    chk("rst_pop_s", 16'(rd_s), 16'd1);
    wait_at(0, 2047);
    chk("rst_f0_m", fw[0], {1'b0, 16'hF0F0, 16'h0000, 16'hF0F0, 15'h0000});
    chk("rst_f0_s", fw[1], {1'b0, 16'hBBBB, 16'h0000, 16'hCCCC, 15'h0000});
    chk("pops_m", 16'(hd[0]), 16'd5);
    chk("pops_s", 16'(hd[1]), 16'd11);
    wait_at(1, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/i2s_fifo_tx.md
# i2s_fifo_tx

Consumer end of the 16-bit audio sample FIFO in the PmodI2S2 MIDI synth. Pops samples from a first-word-fall-through FIFO at the audio frame rate and serializes them as Philips I2S to the PmodI2S2 line-out DAC (CS4344). It also generates MCLK, SCLK and LRCK, and reports FIFO underruns. Runs entirely in the 100 MHz system clock domain.

## Interface
- STEREO, 0, 0: one pop per frame, the sample is sent on both channels; 1: two pops per frame, left then right.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- fifo_dout  in  16  head-of-FIFO sample, two's complement; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO holds no data.
- fifo_rd  out  1  one-clk pop strobe; head word is consumed on the same edge.
- mclk  out  1  DAC master clock, clk/4 (25 MHz).
- sclk  out  1  serial bit clock, clk/32 (3.125 MHz).
- lrck  out  1  word select, clk/2048 (48.83 kHz); 0 = left, 1 = right.
- sdout  out  1  serial data to DAC.
- underrun  out  1  one-clk pulse when a scheduled pop finds fifo_empty=1.
- underrun_cnt  out  8  saturating count of underruns.

## Operation
- Free-running 11-bit counter cnt increments every clk and wraps 2047->0.
- mclk=cnt[1], sclk=cnt[4], lrck=cnt[10]. These are direct register bits, so they are glitch-free.
- Bit slot k=cnt[10:5] (0..63); 32 slots per channel.
- Slot contents:
  - k=0: 0.
  - k=1..16: L[15..0], MSB first.
  - k=17..32: 0.
  - k=33..48: R[15..0], MSB first.
  - k=49..63: 0.
- This is I2S with a one-bit delay after the LRCK edge, 16 valid bits in a 32-bit slot, zero-padded.
- sdout is a register. It loads the value for slot k on the edge where cnt becomes 32k, i.e. it is computed when cnt[4:0]=31.
- As a result, sdout and lrck change coincident with the sclk falling edge and are stable at the sclk rising edge (cnt[4:0]=16).
- Pop schedule:
  - cnt=8: pop into l_smp. If STEREO=0, the same word is also loaded into r_smp.
  - cnt=1032 (STEREO=1 only): pop into r_smp.
- Pop rule at a scheduled instant:
  - If fifo_empty=0: fifo_rd=1 for that single clk, and fifo_dout is captured on the same edge.
  - If fifo_empty=1: fifo_rd stays 0, the target register(s) keep their previous value (last sample repeats), underrun pulses for 1 clk, and underrun_cnt increments, saturating at 255.
- fifo_rd is never asserted outside the scheduled instants, never more than once per instant, and never while fifo_empty=1.
- Sample registers change only at cnt=8 and cnt=1032. Slots that read them (from cnt=32 and cnt=1056) see stable values for the whole slot.

## Timing
- Reset values: cnt=0, mclk=0, sclk=0, lrck=0, sdout=0, fifo_rd=0, underrun=0, underrun_cnt=0, l_smp=r_smp=0.
- First pop occurs at the first clk with cnt=8 after rst is released.
- Latency from pop (cnt=8) to L MSB on sdout (cnt=32): 24 clk.
- STEREO=1: latency from pop (cnt=1032) to R MSB on sdout (cnt=1056): 24 clk.
- Throughput: 1 word (STEREO=0) or 2 words (STEREO=1) per 2048 clk.
- Reset mid-frame: all state returns to reset values on the next edge, any pending pop is dropped, and the frame restarts at cnt=0.
- Full FIFO has no effect on this block; only fifo_empty is sampled.
- Simultaneous FIFO write and pop are permitted; this block relies only on fifo_dout being valid while fifo_empty=0.

## Test plan
- Reset: hold rst 5 clk with random inputs -> all outputs 0; after release, fifo_rd is first high at cnt=8.
- Clocks: run 3 frames -> mclk period 4 clk, sclk period 32, lrck period 2048; lrck edges coincide with sclk falling edges.
- Mono: STEREO=0, FIFO preloaded with 0xA5C3 then 0x0001 -> exactly one fifo_rd per frame at cnt=8.
  - Frame 1: slots 1..16 and 33..48 both carry 1010010111000011; all other slots 0.
  - Frame 2: both channels carry 0x0001.
- Stereo: STEREO=1, FIFO holds 0x8001, 0x7FFE -> fifo_rd at cnt=8 and cnt=1032; left slot 0x8001, right slot 0x7FFE.
- Underrun: deliver 0x1234, then leave the FIFO empty -> no fifo_rd, underrun pulses at cnt=8 each frame, 0x1234 repeats on sdout, underrun_cnt increments; after 300 empty frames underrun_cnt=255.
- Mid-frame reset: assert rst at cnt=700 while streaming -> outputs 0 next clk; after release, fifo_rd recurs at cnt=8 with correct data and no double pop.
